// File: rtl/stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stall_ctrl_pkg
//  Description : Shared encodings for the MIPS hazard/stall controller:
//                Tuse/Tnew conventions, default mult/div latencies, the
//                busy-FSM state type and the register-hazard helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package stall_ctrl_pkg;

    // Tuse value meaning "this source register is not read at all".
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Default busy windows of the multiply/divide unit (cycles after start).
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // Multiply/divide unit sequencing states.
    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // True when source register src, needed in tuse cycles, is produced by an
    // E- or M-stage instruction whose result arrives later than that (tnew > tuse).
    // Register 0 is hard-wired to zero and can never be a real dependency.
    function automatic logic reg_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew
    );
        logic hit_e;
        logic hit_m;
        hit_e = (e_a3 == src) && (e_tnew > tuse);
        hit_m = (m_a3 == src) && (m_tnew > tuse);
        return (src != 5'd0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
    endfunction

endpackage : stall_ctrl_pkg
`default_nettype wire

// File: rtl/md_busy_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_ctr
//  Description : Countdown FSM modelling the busy window of the multiply/
//                divide unit. A start loads the latency of the requested
//                operation; busy stays high until the count drains to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_busy_ctr
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,      // asynchronous, active-low
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

    md_state_t        state;
    md_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // State and countdown registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: a start always (re)loads, even mid-window or on the last
    // busy cycle; otherwise BUSY counts down and drops to IDLE at zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (start) begin
            cnt_nxt   = is_div ? DIV_LD : MULT_LD;
            state_nxt = MD_BUSY;
        end else if (state == MD_BUSY) begin
            if (cnt <= CNT_W'(1)) begin
                cnt_nxt   = '0;
                state_nxt = MD_IDLE;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end
    end

    assign busy = (state == MD_BUSY);

endmodule : md_busy_ctr
`default_nettype wire

// File: rtl/stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stall_ctrl
//  Description : Hazard and stall controller for the 5-stage MIPS pipeline.
//                Compares D-stage Tuse against E/M Tnew, holds md
//                instructions while the mult/div unit is busy, drives the
//                PC / IF-ID enables and the ID-EX clear, and counts stall
//                cycles in a saturating performance counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,       // asynchronous, active-low
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_is_md,
    input  logic [4:0]  e_a3,
    input  logic [1:0]  e_tnew,
    input  logic [4:0]  m_a3,
    input  logic [1:0]  m_tnew,
    input  logic        e_md_start,
    input  logic        e_md_div,
    output logic        pc_en,
    output logic        d_en,
    output logic        e_clr,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall;

    // Busy window of the multiply/divide unit.
    md_busy_ctr #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_ctr (
        .clk    (clk),
        .reset  (reset),
        .start  (e_md_start),
        .is_div (e_md_div),
        .busy   (md_busy)
    );

    // Hazard detection: zero-latency, derived from the current-cycle inputs.
    always_comb begin
        stall_rs = reg_hazard(d_rs, d_tuse_rs, e_a3, e_tnew, m_a3, m_tnew);
        stall_rt = reg_hazard(d_rt, d_tuse_rt, e_a3, e_tnew, m_a3, m_tnew);
        // An md op starting in E this cycle is already busy from D's view.
        stall_md = d_is_md && (md_busy || e_md_start);
        stall    = stall_rs || stall_rt || stall_md;
    end

    // A stall freezes PC and IF/ID and injects a bubble into ID/EX.
    assign pc_en = ~stall;
    assign d_en  = ~stall;
    assign e_clr = stall;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule : stall_ctrl
`default_nettype wire
